spi_peripheral: RTL and testbench

- SPI mode-0 (CPOL=0, CPHA=0) responder: the far end of the CPU-side SPI controller.
- Oversamples the external sclk, cs_n and mosi pins on the system clock.
- Assembles received bytes and presents them with a one-cycle valid strobe.
- Serialises a CPU-supplied response byte onto miso, using a one-deep transmit buffer with a valid/ready handshake.

---
 rtl/spi_peripheral.sv | 204 ++++++++++++++++++++
 tb/tb_spi_peripheral.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_peripheral.sv
// ============================================================================
// Module  : spi_peripheral
// Brief   : SPI mode-0 responder with oversampled pins, byte receive strobe
//           and a one-deep transmit buffer with valid/ready handshake.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_peripheral #(
   parameter int               WIDTH = 8,
   parameter logic [WIDTH-1:0] FILL  = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sclk,
   input  logic             cs_n,
   input  logic             mosi,
   output logic             miso,
   output logic             miso_oe,
   output logic [WIDTH-1:0] data_mosi,
   output logic             dv_mosi,
   input  logic [WIDTH-1:0] tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic             busy,
   output logic             frame_err,
   output logic             tx_underrun
);

   localparam int             c_cw   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [c_cw-1:0] c_last = c_cw'(WIDTH - 1);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_t;

   // two-flop synchronisers plus one extra copy for edge detection
   logic sclk_s1_q, sclk_s2_q, sclk_s3_q;
   logic cs_s1_q, cs_s2_q, cs_s3_q;
   logic mosi_s1_q, mosi_s2_q;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] tx_buf_q, tx_buf_d;
   logic             buf_full_q, buf_full_d;
   logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
   logic [WIDTH-2:0] rx_shift_q, rx_shift_d;
   logic [c_cw-1:0]  bit_cnt_q, bit_cnt_d;
   logic             word_done_q, word_done_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             dv_q, dv_d;
   logic             ferr_q, ferr_d;
   logic             urun_q, urun_d;
   logic             miso_q, miso_d;
   logic             oe_q, oe_d;

   logic             w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall;
   logic [WIDTH-1:0] w_load_word;
   logic [WIDTH-1:0] w_rx_next;
   logic [WIDTH-1:0] w_shifted;
   logic             w_load;
   logic             w_write;

   assign w_sclk_rise = sclk_s2_q & ~sclk_s3_q;
   assign w_sclk_fall = ~sclk_s2_q & sclk_s3_q;
   assign w_cs_rise   = cs_s2_q & ~cs_s3_q;
   assign w_cs_fall   = ~cs_s2_q & cs_s3_q;
   assign w_load_word = buf_full_q ? tx_buf_q : FILL;
   assign w_rx_next   = {rx_shift_q, mosi_s2_q};
   assign w_shifted   = {tx_shift_q[WIDTH-2:0], 1'b0};
   assign w_write     = tx_valid & ~buf_full_q;

   always_comb begin
      state_d     = state_q;
      tx_buf_d    = tx_buf_q;
      buf_full_d  = buf_full_q;
      tx_shift_d  = tx_shift_q;
      rx_shift_d  = rx_shift_q;
      bit_cnt_d   = bit_cnt_q;
      word_done_d = word_done_q;
      data_d      = data_q;
      dv_d        = 1'b0;
      ferr_d      = 1'b0;
      urun_d      = 1'b0;
      miso_d      = miso_q;
      oe_d        = oe_q;
      w_load      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            miso_d = 1'b0;
            oe_d   = 1'b0;
            if (w_cs_fall) begin
               w_load      = 1'b1;
               tx_shift_d  = w_load_word;
               urun_d      = ~buf_full_q;
               bit_cnt_d   = '0;
               word_done_d = 1'b0;
               miso_d      = w_load_word[WIDTH-1];
               oe_d        = 1'b1;
               state_d     = ST_ACTIVE;
            end
         end
         default: begin
            // chip-select release takes priority over a coincident sclk rise
            if (w_cs_rise) begin
               state_d = ST_IDLE;
               oe_d    = 1'b0;
               miso_d  = 1'b0;
               ferr_d  = (bit_cnt_q != '0);
            end else if (w_sclk_rise) begin
               rx_shift_d = w_rx_next[WIDTH-2:0];
               if (bit_cnt_q == c_last) begin
                  data_d      = w_rx_next;
                  dv_d        = 1'b1;
                  bit_cnt_d   = '0;
                  word_done_d = 1'b1;
               end else begin
                  bit_cnt_d = bit_cnt_q + c_cw'(1);
               end
            end else if (w_sclk_fall) begin
               if (word_done_q) begin
                  w_load      = 1'b1;
                  tx_shift_d  = w_load_word;
                  urun_d      = ~buf_full_q;
                  word_done_d = 1'b0;
                  miso_d      = w_load_word[WIDTH-1];
               end else begin
                  tx_shift_d = w_shifted;
                  miso_d     = w_shifted[WIDTH-1];
               end
            end
         end
      endcase

      // a write only lands in an empty buffer, so a same-cycle load has already taken FILL
      if (w_write) begin
         tx_buf_d   = tx_data;
         buf_full_d = 1'b1;
      end else if (w_load) begin
         buf_full_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sclk_s1_q   <= 1'b0;
         sclk_s2_q   <= 1'b0;
         sclk_s3_q   <= 1'b0;
         cs_s1_q     <= 1'b1;
         cs_s2_q     <= 1'b1;
         cs_s3_q     <= 1'b1;
         mosi_s1_q   <= 1'b0;
         mosi_s2_q   <= 1'b0;
         state_q     <= ST_IDLE;
         tx_buf_q    <= '0;
         buf_full_q  <= 1'b0;
         tx_shift_q  <= '0;
         rx_shift_q  <= '0;
         bit_cnt_q   <= '0;
         word_done_q <= 1'b0;
         data_q      <= '0;
         dv_q        <= 1'b0;
         ferr_q      <= 1'b0;
         urun_q      <= 1'b0;
         miso_q      <= 1'b0;
         oe_q        <= 1'b0;
      end else begin
         sclk_s1_q   <= sclk;
         sclk_s2_q   <= sclk_s1_q;
         sclk_s3_q   <= sclk_s2_q;
         cs_s1_q     <= cs_n;
         cs_s2_q     <= cs_s1_q;
         cs_s3_q     <= cs_s2_q;
         mosi_s1_q   <= mosi;
         mosi_s2_q   <= mosi_s1_q;
         state_q     <= state_d;
         tx_buf_q    <= tx_buf_d;
         buf_full_q  <= buf_full_d;
         tx_shift_q  <= tx_shift_d;
         rx_shift_q  <= rx_shift_d;
         bit_cnt_q   <= bit_cnt_d;
         word_done_q <= word_done_d;
         data_q      <= data_d;
         dv_q        <= dv_d;
         ferr_q      <= ferr_d;
         urun_q      <= urun_d;
         miso_q      <= miso_d;
         oe_q        <= oe_d;
      end
   end

   assign miso        = miso_q;
   assign miso_oe     = oe_q;
   assign data_mosi   = data_q;
   assign dv_mosi     = dv_q;
   assign tx_ready    = ~buf_full_q;
   assign busy        = (state_q == ST_ACTIVE);
   assign frame_err   = ferr_q;
   assign tx_underrun = urun_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_peripheral.sv
// ============================================================================
// Module  : tb_spi_peripheral
// Brief   : Directed self-checking bench for spi_peripheral (mode 0, WIDTH=8).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_peripheral;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       sclk = 1'b0;
   logic       cs_n = 1'b1;
   logic       mosi = 1'b0;
   logic       miso;
   logic       miso_oe;
   logic [7:0] data_mosi;
   logic       dv_mosi;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic       busy;
   logic       frame_err;
   logic       tx_underrun;

   int tests_run    = 0;
   int tests_failed = 0;
   int dv_cnt       = 0;
   int ferr_cnt     = 0;
   int urun_cnt     = 0;
   logic [7:0] dv_log[$];

   spi_peripheral #(.WIDTH(8), .FILL(8'h00)) dut (
      .clk         (clk),
      .reset       (reset),
      .sclk        (sclk),
      .cs_n        (cs_n),
      .mosi        (mosi),
      .miso        (miso),
      .miso_oe     (miso_oe),
      .data_mosi   (data_mosi),
      .dv_mosi     (dv_mosi),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .busy        (busy),
      .frame_err   (frame_err),
      .tx_underrun (tx_underrun)
   );

   always #5 clk = ~clk;

   // pulse counters sampled on the falling edge, one count per high cycle
   always @(negedge clk) begin
      if (dv_mosi) begin
         dv_cnt++;
         dv_log.push_back(data_mosi);
      end
      if (frame_err)   ferr_cnt++;
      if (tx_underrun) urun_cnt++;
   end

   task automatic wait_clk(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic write_tx(input logic [7:0] d);
      @(negedge clk);
      tx_data  = d;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   // each bit: sclk low for 5 clk with mosi set, sample miso, sclk high for 5 clk
   task automatic spi_bits(input logic [7:0] mo, input int n, output logic [7:0] mi);
      mi = 8'h00;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         sclk = 1'b0;
         mosi = mo[7-i];
         wait_clk(5);
         mi[7-i] = miso;
         sclk = 1'b1;
         wait_clk(5);
      end
   endtask

   task automatic start_frame();
      @(negedge clk);
      cs_n = 1'b0;
      wait_clk(5);
   endtask

   task automatic end_frame();
      @(negedge clk);
      sclk = 1'b0;
      wait_clk(5);
      cs_n = 1'b1;
      wait_clk(6);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      wait_clk(3);
      reset = 1'b0;
      wait_clk(8);
      tests_run++;
      if ({miso, miso_oe, dv_mosi, busy, frame_err, tx_underrun} !== 6'b0) begin
         tests_failed++;
         $display("FAIL reset_flags got %b want 000000",
                  {miso, miso_oe, dv_mosi, busy, frame_err, tx_underrun});
      end
      tests_run++;
      if (data_mosi !== 8'h00) begin
         tests_failed++;
         $display("FAIL reset_data got %h want 00", data_mosi);
      end
      tests_run++;
      if (tx_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_tx_ready got %b want 1", tx_ready);
      end
   endtask

   task automatic test_single_word();
      logic [7:0] mi;
      int dv0, ur0;
      write_tx(8'hA5);
      tests_run++;
      if (tx_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL single_tx_ready_after_write got %b want 0", tx_ready);
      end
      dv0 = dv_cnt;
      ur0 = urun_cnt;
      start_frame();
      tests_run++;
      if ({busy, miso_oe, tx_ready} !== 3'b111) begin
         tests_failed++;
         $display("FAIL single_active got %b want 111", {busy, miso_oe, tx_ready});
      end
      spi_bits(8'h3C, 8, mi);
      tests_run++;
      if (mi !== 8'hA5) begin
         tests_failed++;
         $display("FAIL single_miso got %h want a5", mi);
      end
      tests_run++;
      if (data_mosi !== 8'h3C) begin
         tests_failed++;
         $display("FAIL single_data got %h want 3c", data_mosi);
      end
      tests_run++;
      if (dv_cnt - dv0 !== 1) begin
         tests_failed++;
         $display("FAIL single_dv_cycles got %0d want 1", dv_cnt - dv0);
      end
      tests_run++;
      if (urun_cnt - ur0 !== 0) begin
         tests_failed++;
         $display("FAIL single_underrun got %0d want 0", urun_cnt - ur0);
      end
      end_frame();
      tests_run++;
      if ({busy, miso_oe, miso} !== 3'b000) begin
         tests_failed++;
         $display("FAIL single_idle got %b want 000", {busy, miso_oe, miso});
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] mi0, mi1;
      int dv0, ur0, fe0;
      write_tx(8'h11);
      dv0 = dv_cnt;
      ur0 = urun_cnt;
      fe0 = ferr_cnt;
      start_frame();
      tests_run++;
      if (tx_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL b2b_ready_after_load got %b want 1", tx_ready);
      end
      write_tx(8'h22);
      tests_run++;
      if (tx_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL b2b_ready_after_write got %b want 0", tx_ready);
      end
      spi_bits(8'hF0, 8, mi0);
      spi_bits(8'h0F, 8, mi1);
      tests_run++;
      if ({mi0, mi1} !== 16'h1122) begin
         tests_failed++;
         $display("FAIL b2b_miso got %h want 1122", {mi0, mi1});
      end
      tests_run++;
      if (dv_cnt - dv0 !== 2) begin
         tests_failed++;
         $display("FAIL b2b_dv_count got %0d want 2", dv_cnt - dv0);
      end else begin
         tests_run++;
         if ({dv_log[dv_log.size()-2], dv_log[dv_log.size()-1]} !== 16'hF00F) begin
            tests_failed++;
            $display("FAIL b2b_rx_words got %h%h want f00f",
                     dv_log[dv_log.size()-2], dv_log[dv_log.size()-1]);
         end
      end
      tests_run++;
      if (urun_cnt - ur0 !== 0) begin
         tests_failed++;
         $display("FAIL b2b_underrun got %0d want 0", urun_cnt - ur0);
      end
      end_frame();
      tests_run++;
      if (ferr_cnt - fe0 !== 0) begin
         tests_failed++;
         $display("FAIL b2b_frame_err got %0d want 0", ferr_cnt - fe0);
      end
   endtask

   task automatic test_underrun();
      logic [7:0] mi;
      int dv0, ur0;
      dv0 = dv_cnt;
      ur0 = urun_cnt;
      start_frame();
      tests_run++;
      if (urun_cnt - ur0 !== 1) begin
         tests_failed++;
         $display("FAIL urun_pulse got %0d want 1", urun_cnt - ur0);
      end
      spi_bits(8'h5A, 8, mi);
      tests_run++;
      if (mi !== 8'h00) begin
         tests_failed++;
         $display("FAIL urun_miso got %h want 00", mi);
      end
      tests_run++;
      if (data_mosi !== 8'h5A || dv_cnt - dv0 !== 1) begin
         tests_failed++;
         $display("FAIL urun_data got %h/%0d want 5a/1", data_mosi, dv_cnt - dv0);
      end
      end_frame();
   endtask

   task automatic test_frame_err();
      logic [7:0] mi;
      int dv0, fe0;
      dv0 = dv_cnt;
      fe0 = ferr_cnt;
      start_frame();
      spi_bits(8'hFF, 5, mi);
      end_frame();
      tests_run++;
      if (ferr_cnt - fe0 !== 1) begin
         tests_failed++;
         $display("FAIL ferr_pulse got %0d want 1", ferr_cnt - fe0);
      end
      tests_run++;
      if (dv_cnt - dv0 !== 0) begin
         tests_failed++;
         $display("FAIL ferr_no_dv got %0d want 0", dv_cnt - dv0);
      end
      tests_run++;
      if (data_mosi !== 8'h5A || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL ferr_hold got %h/%b want 5a/0", data_mosi, busy);
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] mi;
      int dv0;
      start_frame();
      write_tx(8'h77);
      spi_bits(8'hE0, 3, mi);
      @(negedge clk);
      reset = 1'b1;
      #1;
      tests_run++;
      if ({miso_oe, busy, tx_ready} !== 3'b001) begin
         tests_failed++;
         $display("FAIL rst_async got %b want 001", {miso_oe, busy, tx_ready});
      end
      sclk = 1'b0;
      cs_n = 1'b1;
      wait_clk(3);
      reset = 1'b0;
      wait_clk(4);
      write_tx(8'hC3);
      dv0 = dv_cnt;
      start_frame();
      spi_bits(8'h81, 8, mi);
      tests_run++;
      if (mi !== 8'hC3) begin
         tests_failed++;
         $display("FAIL rst_miso got %h want c3", mi);
      end
      tests_run++;
      if (data_mosi !== 8'h81 || dv_cnt - dv0 !== 1) begin
         tests_failed++;
         $display("FAIL rst_data got %h/%0d want 81/1", data_mosi, dv_cnt - dv0);
      end
      end_frame();
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_back_to_back();
      test_underrun();
      test_frame_err();
      test_reset_mid_frame();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

`default_nettype wire
